// File: rtl/rr_reg_write_arbiter_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
package rr_arb_pkg;

    localparam int unsigned MAXREQ  = 8;
    localparam int unsigned MAXIDXW = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Requester index width; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAXREQ-1:0] onehot(input logic [MAXIDXW-1:0] idx);
        logic [MAXREQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_reg_write_arbiter_if.sv
// Requester-side bus of the shared register: requests, data, grant and stored value.
interface rr_reg_write_arbiter_if
    import rr_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int IDXW = idx_width(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic [WIDTH-1:0]      q;
    logic [IDXW-1:0]       q_owner;
    logic                  q_valid;

    modport master (
        output req, wdata,
        input  gnt, busy, q, q_owner, q_valid
    );

    modport slave (
        input  req, wdata,
        output gnt, busy, q, q_owner, q_valid
    );
endinterface

// File: rtl/rr_reg_write_arbiter_pick.sv
// Round-robin winner selection: first set request at or after ptr, wrapping.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]             req,
    input  logic [idx_width(NREQ)-1:0]  ptr,
    output logic [idx_width(NREQ)-1:0]  win,
    output logic                        any
);
    localparam int IDXW = idx_width(NREQ);

    logic [2*NREQ-1:0] dbl;
    logic [2*NREQ-1:0] masked;
    logic              hit;

    // Lower copy masked below ptr; the unmasked upper copy supplies the wrap-around.
    always_comb begin
        dbl    = {req, req};
        masked = '0;
        hit    = 1'b0;
        win    = '0;
        for (int unsigned i = 0; i < 2*NREQ; i++) begin
            masked[i] = dbl[i] && (i >= 32'(ptr));
        end
        for (int unsigned i = 0; i < 2*NREQ; i++) begin
            if (!hit && masked[i]) begin
                hit = 1'b1;
                win = IDXW'(i % NREQ);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rr_reg_write_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among NREQ writers.
module rr_reg_write_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input logic                    clk,
    input logic                    rst,
    rr_reg_write_arbiter_if.slave  bus
);
    localparam int IDXW = idx_width(NREQ);

    state_t            state;
    logic [IDXW-1:0]   ptr;
    logic [IDXW-1:0]   win;
    logic [IDXW-1:0]   win_q;
    logic              any;
    logic [NREQ-1:0]   win_oh;
    logic [NREQ-1:0]   gnt_r;
    logic              busy_r;
    logic [WIDTH-1:0]  q_r;
    logic [IDXW-1:0]   owner_r;
    logic              valid_r;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (bus.req),
        .ptr (ptr),
        .win (win),
        .any (any)
    );

    assign win_oh = NREQ'(onehot(MAXIDXW'(win)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt_r   <= '0;
            busy_r  <= 1'b0;
            q_r     <= '0;
            owner_r <= '0;
            valid_r <= 1'b0;
            ptr     <= '0;
            win_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        gnt_r  <= win_oh;
                        busy_r <= 1'b1;
                        win_q  <= win;
                        state  <= GRANT;
                    end else begin
                        gnt_r  <= '0;
                    end
                end
                GRANT: begin
                    // Data is taken at the closing edge, not at request time.
                    q_r     <= bus.wdata[win_q*WIDTH +: WIDTH];
                    owner_r <= win_q;
                    valid_r <= 1'b1;
                    ptr     <= (win_q == IDXW'(NREQ-1)) ? '0 : win_q + 1'b1;
                    gnt_r   <= '0;
                    busy_r  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.busy    = busy_r;
    assign bus.q       = q_r;
    assign bus.q_owner = owner_r;
    assign bus.q_valid = valid_r;

endmodule

// File: tb/tb_rr_reg_write_arbiter.sv
// Directed bench for rr_reg_write_arbiter with NREQ=4, WIDTH=8.
module tb_rr_reg_write_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    rr_reg_write_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

    rr_reg_write_arbiter #(.NREQ(4), .WIDTH(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Structural invariants, checked every cycle after reset.
    always @(negedge clk) begin
        if (!rst) begin
            n_cmp++;
            if ((bus.gnt & (bus.gnt - 4'd1)) !== 4'd0) begin
                n_err++;
                $display("FAIL gnt_onehot: gnt=%b required zero or one-hot", bus.gnt);
            end
            n_cmp++;
            if ((bus.gnt != 4'd0) !== bus.busy) begin
                n_err++;
                $display("FAIL gnt_busy: gnt=%b busy=%b required gnt!=0 iff busy", bus.gnt, bus.busy);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wdata(input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3);
        bus.wdata = {d3, d2, d1, d0};
    endtask

    task automatic chk_gnt(input string tag, input logic [3:0] exp_gnt, input logic exp_busy);
        n_cmp++;
        if (bus.gnt !== exp_gnt) begin
            n_err++;
            $display("FAIL %s gnt: got %b required %b", tag, bus.gnt, exp_gnt);
        end
        n_cmp++;
        if (bus.busy !== exp_busy) begin
            n_err++;
            $display("FAIL %s busy: got %b required %b", tag, bus.busy, exp_busy);
        end
    endtask

    task automatic chk_q(input string tag, input logic [7:0] exp_q,
                         input logic [1:0] exp_owner, input logic exp_valid);
        n_cmp++;
        if (bus.q !== exp_q) begin
            n_err++;
            $display("FAIL %s q: got %h required %h", tag, bus.q, exp_q);
        end
        n_cmp++;
        if (bus.q_owner !== exp_owner) begin
            n_err++;
            $display("FAIL %s q_owner: got %0d required %0d", tag, bus.q_owner, exp_owner);
        end
        n_cmp++;
        if (bus.q_valid !== exp_valid) begin
            n_err++;
            $display("FAIL %s q_valid: got %b required %b", tag, bus.q_valid, exp_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 4'b1111;
        set_wdata(8'h01, 8'h02, 8'h03, 8'h04);
        step();
        step();
        chk_gnt("reset", 4'b0000, 1'b0);
        chk_q("reset", 8'h00, 2'd0, 1'b0);
        rst = 1'b0;
        step();
        chk_gnt("first_grant", 4'b0001, 1'b1);
        bus.req = 4'b0000;
        step();
        chk_gnt("first_commit", 4'b0000, 1'b0);
        chk_q("first_commit", 8'h01, 2'd0, 1'b1);
    endtask

    // ptr is 1 on entry.
    task automatic test_single();
        bus.req = 4'b0100;
        set_wdata(8'h00, 8'h00, 8'hA5, 8'h00);
        step();
        chk_gnt("single_grant", 4'b0100, 1'b1);
        bus.req = 4'b0000;
        step();
        chk_gnt("single_commit", 4'b0000, 1'b0);
        chk_q("single_commit", 8'hA5, 2'd2, 1'b1);
        // ptr is now 3: requester 3 must beat all others.
        bus.req = 4'b1111;
        set_wdata(8'h10, 8'h11, 8'h12, 8'h13);
        step();
        chk_gnt("ptr_after_2", 4'b1000, 1'b1);
        step();
        chk_q("ptr_after_2_commit", 8'h13, 2'd3, 1'b1);
    endtask

    // ptr is 0 on entry, req=1111 still held.
    task automatic test_round_robin();
        logic [3:0] exp_oh;
        for (int k = 0; k < 5; k++) begin
            exp_oh = 4'b0001 << (k % 4);
            step();
            chk_gnt($sformatf("rr_grant%0d", k), exp_oh, 1'b1);
            if (k == 4) bus.req = 4'b0000;
            step();
            chk_gnt($sformatf("rr_commit%0d", k), 4'b0000, 1'b0);
            chk_q($sformatf("rr_commit%0d", k), 8'h10 + 8'(k % 4), 2'(k % 4), 1'b1);
        end
    endtask

    // ptr is 1 on entry.
    task automatic test_wrap();
        bus.req = 4'b1000;
        set_wdata(8'h20, 8'h21, 8'h22, 8'h23);
        step();
        chk_gnt("wrap_g3", 4'b1000, 1'b1);
        bus.req = 4'b1001;
        step();
        chk_q("wrap_c3", 8'h23, 2'd3, 1'b1);
        step();
        chk_gnt("wrap_g0", 4'b0001, 1'b1);
        step();
        chk_q("wrap_c0", 8'h20, 2'd0, 1'b1);
        step();
        chk_gnt("wrap_g3b", 4'b1000, 1'b1);
        bus.req = 4'b0000;
        step();
        chk_q("wrap_c3b", 8'h23, 2'd3, 1'b1);
    endtask

    // ptr is 0 on entry.
    task automatic test_drop_mid_grant();
        bus.req = 4'b0010;
        set_wdata(8'h00, 8'h3C, 8'h00, 8'h00);
        step();
        chk_gnt("drop_grant", 4'b0010, 1'b1);
        bus.req = 4'b0000;
        step();
        chk_q("drop_commit", 8'h3C, 2'd1, 1'b1);
        step();
        chk_gnt("drop_idle1", 4'b0000, 1'b0);
        step();
        chk_gnt("drop_idle2", 4'b0000, 1'b0);
        chk_q("drop_hold", 8'h3C, 2'd1, 1'b1);
    endtask

    // ptr is 2 on entry; after reset it must be 0 again.
    task automatic test_reset_mid_grant();
        bus.req = 4'b0001;
        set_wdata(8'hFF, 8'h00, 8'h00, 8'h00);
        step();
        chk_gnt("rstmid_grant", 4'b0001, 1'b1);
        rst = 1'b1;
        step();
        chk_gnt("rstmid_cut", 4'b0000, 1'b0);
        chk_q("rstmid_cut", 8'h00, 2'd0, 1'b0);
        rst = 1'b0;
        bus.req = 4'b1111;
        step();
        chk_gnt("rstmid_restart", 4'b0001, 1'b1);
        bus.req = 4'b0000;
        step();
        chk_q("rstmid_commit", 8'hFF, 2'd0, 1'b1);
    endtask

    initial begin
        bus.req   = '0;
        bus.wdata = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_drop_mid_grant();
        test_reset_mid_grant();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
